// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared constants and types for the traffic-light controller slice.
//   NUM_REQ                  number of pushbutton request channels
//   req_idx_t                symbolic channel indices
//   DEFAULT_DEBOUNCE_CYCLES  stable cycles needed to accept a level change
//   DEFAULT_AGE_W            width of each wait-age counter
//   DEFAULT_URGENT_AGE       age at or above which a pending request is urgent
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        REQ_SB_LEFT = 2'd0,
        REQ_NS_WALK = 2'd1,
        REQ_EW_WALK = 2'd2
    } req_idx_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 3;
    localparam int DEFAULT_AGE_W           = 8;
    localparam int DEFAULT_URGENT_AGE      = 100;

endpackage

// File: rtl/request_channel.sv
// -----------------------------------------------------------------------------
// request_channel
// One pushbutton channel: two-flop synchroniser, debouncer, rising-edge
// detector, sticky pending request and saturating wait-age counter.
//   clk          system clock
//   reset        asynchronous active-high reset
//   raw          raw button level, asynchronous to clk
//   ack          service strobe; clears a pending request
//   pending      sticky pending request
//   press_pulse  one-cycle pulse on each accepted press
//   urgent       pending and age >= URGENT_AGE
//   age          cycles since the request was (re)registered, saturating
// -----------------------------------------------------------------------------
module request_channel
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int AGE_W           = DEFAULT_AGE_W,
    parameter int URGENT_AGE      = DEFAULT_URGENT_AGE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw,
    input  logic             ack,
    output logic             pending,
    output logic             press_pulse,
    output logic             urgent,
    output logic [AGE_W-1:0] age
);

    localparam int               CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX    = '1;
    localparam logic [AGE_W-1:0] AGE_URGENT = AGE_W'(URGENT_AGE);

    logic             sync_meta;
    logic             sync_s;
    logic             deb;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // A press is accepted on the edge where the debounced level flips 0->1.
    assign accept = sync_s && !deb && (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchroniser relies on it).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_s    <= sync_meta;
        end
    end

    // Counter measures how long the synchronised level has disagreed with
    // the debounced level; any agreement restarts it, discarding glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync_s == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= sync_s;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A fresh press outranks a same-edge ack: the request stays pending and
    // its age restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_pulse <= 1'b0;
            pending     <= 1'b0;
            age         <= '0;
        end else begin
            press_pulse <= accept;
            if (accept) begin
                pending <= 1'b1;
                age     <= '0;
            end else if (!pending || ack) begin
                pending <= 1'b0;
                age     <= '0;
            end else if (age != AGE_MAX) begin
                age <= age + 1'b1;
            end
        end
    end

    assign urgent = pending && (age >= AGE_URGENT);

endmodule

// File: rtl/request_conditioner.sv
// -----------------------------------------------------------------------------
// request_conditioner
// Conditions the pushbutton requests ahead of the traffic controller FSM and
// reports which waiting channel is oldest.
//   clk              system clock (same clock as the FSM)
//   reset            asynchronous active-high reset
//   req_raw          raw active-high button levels, asynchronous to clk
//   req_ack          per-channel service strobe from the FSM
//   req_pending      sticky pending request per channel
//   req_press_pulse  one-cycle pulse per accepted press
//   req_urgent       pending and age >= URGENT_AGE
//   any_pending      OR of req_pending
//   oldest_idx       pending channel with the largest age (ties -> lowest)
//   req_age          packed ages, channel i at [i*AGE_W +: AGE_W]
// -----------------------------------------------------------------------------
module request_conditioner #(
    parameter int NUM_REQ         = traffic_pkg::NUM_REQ,
    parameter int DEBOUNCE_CYCLES = traffic_pkg::DEFAULT_DEBOUNCE_CYCLES,
    parameter int AGE_W           = traffic_pkg::DEFAULT_AGE_W,
    parameter int URGENT_AGE      = traffic_pkg::DEFAULT_URGENT_AGE,
    localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_raw,
    input  logic [NUM_REQ-1:0]       req_ack,
    output logic [NUM_REQ-1:0]       req_pending,
    output logic [NUM_REQ-1:0]       req_press_pulse,
    output logic [NUM_REQ-1:0]       req_urgent,
    output logic                     any_pending,
    output logic [IDX_W-1:0]         oldest_idx,
    output logic [NUM_REQ*AGE_W-1:0] req_age
);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
        request_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .AGE_W          (AGE_W),
            .URGENT_AGE     (URGENT_AGE)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .raw        (req_raw[i]),
            .ack        (req_ack[i]),
            .pending    (req_pending[i]),
            .press_pulse(req_press_pulse[i]),
            .urgent     (req_urgent[i]),
            .age        (req_age[i*AGE_W +: AGE_W])
        );
    end

    assign any_pending = |req_pending;

    logic [AGE_W-1:0] best_age;
    logic             found;

    // Strict greater-than keeps the lowest index on equal ages.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        oldest_idx = '0;
        best_age   = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_pending[i] && (!found || (req_age[i*AGE_W +: AGE_W] > best_age))) begin
                oldest_idx = IDX_W'(i);
                best_age   = req_age[i*AGE_W +: AGE_W];
                found      = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_request_conditioner.sv
// -----------------------------------------------------------------------------
// tb_request_conditioner
// Self-checking bench for request_conditioner: a vector table, directed
// multi-cycle sequences and a randomised run against a reference model.
// -----------------------------------------------------------------------------
module tb_request_conditioner;
    import traffic_pkg::*;

    localparam int N    = NUM_REQ;
    localparam int D    = DEFAULT_DEBOUNCE_CYCLES;
    localparam int AW   = DEFAULT_AGE_W;
    localparam int UA   = DEFAULT_URGENT_AGE;
    localparam int AMAX = (1 << AW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_raw;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    req_pending;
    logic [N-1:0]    req_press_pulse;
    logic [N-1:0]    req_urgent;
    logic            any_pending;
    logic [1:0]      oldest_idx;
    logic [N*AW-1:0] req_age;

    int n_checks = 0;
    int n_errors = 0;

    request_conditioner dut (
        .clk            (clk),
        .reset          (reset),
        .req_raw        (req_raw),
        .req_ack        (req_ack),
        .req_pending    (req_pending),
        .req_press_pulse(req_press_pulse),
        .req_urgent     (req_urgent),
        .any_pending    (any_pending),
        .oldest_idx     (oldest_idx),
        .req_age        (req_age)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] age_of(input int ch);
        return 32'(req_age[ch*AW +: AW]);
    endfunction

    // ---------------- reference model ----------------
    // Button samples are remembered per edge; the level the debouncer sees
    // is the sample taken two edges earlier. A level is accepted after D
    // consecutive disagreeing samples.
    logic [N-1:0] raw_hist[$];
    bit           m_deb[N];
    int           m_streak[N];
    bit           m_pend[N];
    bit           m_pulse[N];
    int           m_age[N];

    task automatic model_reset();
        raw_hist.delete();
        for (int c = 0; c < N; c++) begin
            m_deb[c] = 0; m_streak[c] = 0; m_pend[c] = 0; m_pulse[c] = 0; m_age[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] seen;
        bit           pressed;
        seen = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : '0;
        raw_hist.push_back(req_raw);
        if (raw_hist.size() > 4) void'(raw_hist.pop_front());
        for (int c = 0; c < N; c++) begin
            pressed = 0;
            if (seen[c] != m_deb[c]) begin
                m_streak[c]++;
                if (m_streak[c] == D) begin
                    m_deb[c]    = seen[c];
                    m_streak[c] = 0;
                    pressed     = seen[c];
                end
            end else begin
                m_streak[c] = 0;
            end
            m_pulse[c] = pressed;
            if (pressed) begin
                m_pend[c] = 1; m_age[c] = 0;
            end else if (m_pend[c] && req_ack[c]) begin
                m_pend[c] = 0; m_age[c] = 0;
            end else if (m_pend[c]) begin
                m_age[c] = (m_age[c] < AMAX) ? m_age[c] + 1 : AMAX;
            end
        end
    endtask

    task automatic compare_model(input int cyc);
        logic [N-1:0] e_pend, e_pulse, e_urg;
        int           best, best_age;
        best = 0; best_age = -1;
        for (int c = 0; c < N; c++) begin
            e_pend[c]  = m_pend[c];
            e_pulse[c] = m_pulse[c];
            e_urg[c]   = m_pend[c] && (m_age[c] >= UA);
            if (m_pend[c] && m_age[c] > best_age) begin
                best = c; best_age = m_age[c];
            end
            check($sformatf("rnd%0d age%0d", cyc, c), age_of(c), 32'(m_age[c]));
        end
        check($sformatf("rnd%0d pending", cyc), 32'(req_pending), 32'(e_pend));
        check($sformatf("rnd%0d pulse", cyc), 32'(req_press_pulse), 32'(e_pulse));
        check($sformatf("rnd%0d urgent", cyc), 32'(req_urgent), 32'(e_urg));
        check($sformatf("rnd%0d any", cyc), 32'(any_pending), 32'(e_pend != 0));
        check($sformatf("rnd%0d oldest", cyc), 32'(oldest_idx), 32'(best));
    endtask

    // ---------------- stimulus helpers ----------------
    // Inputs change at negedge; the model sees the same values the DUT samples.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req_raw = '0;
        req_ack = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] ack;
        logic [N-1:0] exp_pend;
        logic [N-1:0] exp_pulse;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset   = 1'b1;
        req_raw = '0;
        req_ack = '0;
        model_reset();
        #1;
        check("reset pending", 32'(req_pending), 0);
        check("reset age", 32'(req_age), 0);
        check("reset any", 32'(any_pending), 0);
        do_reset();

        // Clean press ch0, glitch ch2, ignored ack ch2, ack ch0.
        for (int k = 0; k < 4; k++) tbl.push_back('{3'b001, 3'b000, 3'b000, 3'b000});
        tbl.push_back('{3'b001, 3'b000, 3'b001, 3'b001});
        for (int k = 0; k < 2; k++) tbl.push_back('{3'b000, 3'b000, 3'b001, 3'b000});
        for (int k = 0; k < 2; k++) tbl.push_back('{3'b100, 3'b000, 3'b001, 3'b000});
        for (int k = 0; k < 5; k++) tbl.push_back('{3'b000, 3'b000, 3'b001, 3'b000});
        tbl.push_back('{3'b000, 3'b100, 3'b001, 3'b000});
        tbl.push_back('{3'b000, 3'b001, 3'b000, 3'b000});
        tbl.push_back('{3'b000, 3'b000, 3'b000, 3'b000});
        foreach (tbl[i]) begin
            req_raw = tbl[i].raw;
            req_ack = tbl[i].ack;
            tick();
            check($sformatf("tbl%0d pending", i), 32'(req_pending), 32'(tbl[i].exp_pend));
            check($sformatf("tbl%0d pulse", i), 32'(req_press_pulse), 32'(tbl[i].exp_pulse));
            check($sformatf("tbl%0d any", i), 32'(any_pending), 32'(tbl[i].exp_pend != 0));
        end

        // Reset in the middle of a ch1 debounce, with ch0 pending.
        req_raw = 3'b001;
        ticks(5);
        req_raw = 3'b010;
        ticks(4);
        check("midrst pre pending", 32'(req_pending), 32'b001);
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst pending", 32'(req_pending), 0);
        check("midrst age", 32'(req_age), 0);
        check("midrst any", 32'(any_pending), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= D + 2; k++) begin
            tick();
            check($sformatf("midrst edge%0d pulse", k), 32'(req_press_pulse),
                  (k == D + 2) ? 32'b010 : 32'b000);
        end
        check("midrst pending after", 32'(req_pending), 32'b010);

        // Held button: single pulse, age grows; then ack clears ch1.
        ticks(10);
        check("hold age1", age_of(1), 10);
        check("hold pulse", 32'(req_press_pulse), 0);
        req_ack = 3'b010;
        tick();
        req_ack = 3'b000;
        check("ack1 pending", 32'(req_pending), 0);
        check("ack1 age", age_of(1), 0);

        // Press/ack collision on ch0 while already pending.
        req_raw = 3'b011;
        ticks(D + 2);
        check("coll first pending", 32'(req_pending), 32'b001);
        req_raw = 3'b010;
        ticks(8);
        check("coll age before", age_of(0), 8);
        req_raw = 3'b011;
        ticks(D + 1);
        req_ack = 3'b001;
        tick();
        req_ack = 3'b000;
        check("coll pending", 32'(req_pending), 32'b001);
        check("coll age", age_of(0), 0);
        check("coll pulse", 32'(req_press_pulse), 32'b001);
        tick();
        check("coll age next", age_of(0), 1);

        // Ageing, urgency boundary and arbitration.
        do_reset();
        req_raw = 3'b100;
        ticks(20);
        req_raw = 3'b101;
        ticks(84);
        check("arb urgent at 99", 32'(req_urgent), 0);
        check("arb oldest pre", 32'(oldest_idx), 2);
        tick();
        check("arb age2", age_of(2), 100);
        check("arb age0", age_of(0), 80);
        check("arb urgent at 100", 32'(req_urgent), 32'b100);
        check("arb oldest", 32'(oldest_idx), 2);
        req_ack = 3'b100;
        tick();
        req_ack = 3'b000;
        check("arb oldest after ack", 32'(oldest_idx), 0);
        check("arb pending after ack", 32'(req_pending), 32'b001);
        ticks(1 << AW);
        check("sat age0", age_of(0), AMAX);
        check("sat urgent", 32'(req_urgent), 32'b001);

        // Equal ages tie to the lowest index.
        do_reset();
        req_raw = 3'b110;
        ticks(D + 2 + 3);
        check("tie pending", 32'(req_pending), 32'b110);
        check("tie oldest", 32'(oldest_idx), 1);

        // Randomised run against the model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 11) == 0) req_raw[c] = ~req_raw[c];
                req_ack[c] = ($urandom_range(0, 19) == 0);
            end
            tick();
            compare_model(cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
